multadd_seq_ctrl: RTL

Command-driven sequencer for one multadd datapath lane. It accepts a vector op (add/sub/mul elementwise, or dot product), streams element pairs from the vector register file into multadd, and drives alu_op/use_fma/fma_first. Results are written back after the fixed multadd latency. It sits between the vector issue stage and a single shared multadd instance.

---
 rtl/multadd_seq_pkg.sv | 36 +++
 rtl/multadd_seq_wb_pipe.sv | 35 +++
 rtl/multadd_seq_ctrl.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/multadd_seq_pkg.sv
// Shared types for the multadd vector sequencer.
//   op_e       : vector command opcode (elementwise add/sub/mul, dot product)
//   state_e    : sequencer FSM states
//   ALU_*      : multadd alu_op encodings
//   wb_entry_s : one slot of the writeback delay line
package multadd_seq_pkg;

  typedef enum logic [1:0] {
    OpAdd = 2'd0,
    OpSub = 2'd1,
    OpMul = 2'd2,
    OpDot = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } state_e;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_MUL = 2'd2;

  // Element index field is sized for the largest supported vector; the top
  // truncates it to its own index width.
  localparam int unsigned WbElW = 8;

  typedef struct packed {
    logic             valid;
    logic [WbElW-1:0] el;
    logic             is_last;
  } wb_entry_s;

endpackage

// File: rtl/multadd_seq_wb_pipe.sv
// Writeback delay line: carries {valid, el, is_last} for each issued element
// so it emerges exactly when multadd presents the matching result.
//   clk_i    : clock
//   reset_i  : synchronous active-high flush (clears every slot)
//   entry_i  : entry pushed in the issue cycle
//   entry_o  : entry aligned with ma_data_i, lat_p cycles later
module multadd_seq_wb_pipe
  import multadd_seq_pkg::*;
#(
  parameter int unsigned lat_p = 1
) (
  input  logic      clk_i,
  input  logic      reset_i,
  input  wb_entry_s entry_i,
  output wb_entry_s entry_o
);

  wb_entry_s stage_q [lat_p];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < lat_p; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= entry_i;
      for (int i = 1; i < lat_p; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign entry_o = stage_q[lat_p-1];

endmodule

// File: rtl/multadd_seq_ctrl.sv
// Command-driven sequencer for one multadd lane. Accepts a vector op, streams
// element pairs from the vector register file into multadd, and writes the
// results back after the fixed multadd latency.
//   clk_i, reset_i            : clock, synchronous active-high reset
//   v_i/ready_o, op_i, vs1_i, vs2_i, vd_i, len_i : command handshake and fields
//   rd_*                      : register-file read port (combinational data)
//   ma_*                      : multadd operand/control drive and result
//   wr_*                      : writeback port
//   done_o                    : one-cycle completion pulse
//   ovf_o                     : sticky overflow, cleared on accept
// Optional: define MULTADD_SEQ_PERF_EN to add perf_busy_o, a saturating count
// of non-idle cycles.
module multadd_seq_ctrl
  import multadd_seq_pkg::*;
#(
  parameter int unsigned vdw_p   = 32,
  parameter int unsigned els_p   = 8,
  parameter int unsigned vregs_p = 8,
  parameter int unsigned lat_p   = 1
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         v_i,
  output logic                         ready_o,
  input  logic [1:0]                   op_i,
  input  logic [$clog2(vregs_p)-1:0]   vs1_i,
  input  logic [$clog2(vregs_p)-1:0]   vs2_i,
  input  logic [$clog2(vregs_p)-1:0]   vd_i,
  input  logic [$clog2(els_p+1)-1:0]   len_i,
  output logic                         rd_v_o,
  output logic [$clog2(vregs_p)-1:0]   rd_reg_a_o,
  output logic [$clog2(vregs_p)-1:0]   rd_reg_b_o,
  output logic [$clog2(els_p)-1:0]     rd_el_o,
  input  logic [vdw_p-1:0]             rd_a_i,
  input  logic [vdw_p-1:0]             rd_b_i,
  output logic [vdw_p-1:0]             ma_a_o,
  output logic [vdw_p-1:0]             ma_b_o,
  output logic [1:0]                   ma_alu_op_o,
  output logic                         ma_use_fma_o,
  output logic                         ma_fma_first_o,
  input  logic [vdw_p-1:0]             ma_data_i,
  input  logic                         ma_overflow_i,
  output logic                         wr_v_o,
  output logic [$clog2(vregs_p)-1:0]   wr_reg_o,
  output logic [$clog2(els_p)-1:0]     wr_el_o,
  output logic [vdw_p-1:0]             wr_data_o,
  output logic                         done_o,
`ifdef MULTADD_SEQ_PERF_EN
  output logic [31:0]                  perf_busy_o,
`endif
  output logic                         ovf_o
);

  localparam int unsigned RegW = $clog2(vregs_p);
  localparam int unsigned ElW  = $clog2(els_p);
  localparam int unsigned LenW = $clog2(els_p+1);

  state_e          state_q, state_d;
  op_e             op_q, op_d;
  logic [RegW-1:0] vs1_q, vs1_d, vs2_q, vs2_d, vd_q, vd_d;
  logic [LenW-1:0] len_q, len_d, len_clamp;
  logic [ElW-1:0]  el_q, el_d;
  logic            ovf_q, ovf_d;

  logic      issue, drain, last_issue, is_dot;
  wb_entry_s wb_in, wb_out;
  logic      unused_el;

  assign issue      = (state_q == StIssue);
  assign drain      = (state_q == StDrain);
  assign is_dot     = (op_q == OpDot);
  assign last_issue = issue && (LenW'(el_q) == len_q - LenW'(1));
  assign len_clamp  = (len_i > LenW'(els_p)) ? LenW'(els_p) : len_i;

  assign wb_in.valid   = issue;
  assign wb_in.el      = WbElW'(el_q);
  assign wb_in.is_last = last_issue;

  multadd_seq_wb_pipe #(
    .lat_p (lat_p)
  ) u_wb_pipe (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .entry_i (wb_in),
    .entry_o (wb_out)
  );

  // Upper index bits only exist to keep the entry type fixed-width.
  assign unused_el = ^(wb_out.el >> ElW);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    vs1_d   = vs1_q;
    vs2_d   = vs2_q;
    vd_d    = vd_q;
    len_d   = len_q;
    el_d    = el_q;
    ovf_d   = ovf_q | (wb_out.valid & ma_overflow_i);
    unique case (state_q)
      StIdle: begin
        if (v_i) begin
          op_d    = op_e'(op_i);
          vs1_d   = vs1_i;
          vs2_d   = vs2_i;
          vd_d    = vd_i;
          len_d   = len_clamp;
          el_d    = '0;
          ovf_d   = 1'b0;
          state_d = (len_clamp == '0) ? StDone : StIssue;
        end
      end
      StIssue: begin
        el_d = el_q + ElW'(1);
        if (last_issue) state_d = StDrain;
      end
      StDrain: begin
        if (wb_out.valid && wb_out.is_last) state_d = StIdle;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      op_q    <= OpAdd;
      vs1_q   <= '0;
      vs2_q   <= '0;
      vd_q    <= '0;
      len_q   <= '0;
      el_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      vs1_q   <= vs1_d;
      vs2_q   <= vs2_d;
      vd_q    <= vd_d;
      len_q   <= len_d;
      el_q    <= el_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ready_o        = (state_q == StIdle);
  assign rd_v_o         = issue;
  assign rd_reg_a_o     = vs1_q;
  assign rd_reg_b_o     = vs2_q;
  assign rd_el_o        = el_q;
  assign ma_a_o         = issue ? rd_a_i : '0;
  assign ma_b_o         = issue ? rd_b_i : '0;
  assign ma_alu_op_o    = (issue && !is_dot) ? 2'(op_q) : ALU_ADD;
  // Keep FMA selected through drain so the accumulator is not disturbed.
  assign ma_use_fma_o   = is_dot && (issue || drain);
  assign ma_fma_first_o = is_dot && issue && (el_q == '0);

  // Dot products only write the final accumulated value, always to element 0.
  assign wr_v_o    = wb_out.valid && (!is_dot || wb_out.is_last);
  assign wr_reg_o  = vd_q;
  assign wr_el_o   = is_dot ? '0 : wb_out.el[ElW-1:0];
  assign wr_data_o = ma_data_i;
  assign done_o    = (state_q == StDone) || (wb_out.valid && wb_out.is_last);
  assign ovf_o     = ovf_q;

`ifdef MULTADD_SEQ_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      perf_q <= '0;
    end else if ((state_q != StIdle) && (perf_q != '1)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_busy_o = perf_q;
`endif

endmodule
